// File: rtl/fetch_unit_pkg.sv
// Shared pipeline constants for the MIPS fetch stage.
package fetch_unit_pkg;

    localparam int unsigned DEF_ADDR_W   = 32;
    localparam int unsigned DEF_CNT_W    = 16;
    localparam int unsigned INSTR_W      = 32;
    localparam int unsigned PC_INC       = 4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module fetch_unit_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// IF stage plus IF/ID register: PC, 1-cycle imem fetch, one-entry skid, flush bubbles.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned        ADDR_W   = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DEF_RESET_PC),
    parameter int unsigned        CNT_W    = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                PCWrite,
    input  logic                IFIDWrite,
    input  logic                Redirect,
    input  logic [ADDR_W-1:0]   RedirectPC,
    output logic                imem_en,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic [INSTR_W-1:0]  IFID_instr,
    output logic [ADDR_W-1:0]   IFID_pc4,
    output logic                IFID_valid,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt
);

    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(PC_INC);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    logic [ADDR_W-1:0]  pcQ;
    logic               inflV;
    logic [ADDR_W-1:0]  inflPc;
    logic               skidV;
    logic [INSTR_W-1:0] skidInstr;
    logic [ADDR_W-1:0]  skidPc;

    // A held full skid blocks new fetches so the skid can never be overrun.
    assign imem_en   = PCWrite & ~Redirect & ~(skidV & ~IFIDWrite);
    assign imem_addr = pcQ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcQ        <= RESET_PC;
            inflV      <= 1'b0;
            inflPc     <= '0;
            skidV      <= 1'b0;
            skidInstr  <= NOP_INSTR;
            skidPc     <= '0;
            IFID_instr <= NOP_INSTR;
            IFID_pc4   <= '0;
            IFID_valid <= 1'b0;
        end else if (Redirect) begin
            // Wrong-path in-flight data and any skid contents are discarded.
            pcQ        <= RedirectPC & ALIGN_MASK;
            inflV      <= 1'b0;
            skidV      <= 1'b0;
            IFID_instr <= NOP_INSTR;
            IFID_valid <= 1'b0;
        end else begin
            if (imem_en) begin
                pcQ    <= pcQ + PC_STEP;
                inflV  <= 1'b1;
                inflPc <= pcQ;
            end else begin
                inflV  <= 1'b0;
            end

            if (IFIDWrite) begin
                if (skidV) begin
                    IFID_instr <= skidInstr;
                    IFID_pc4   <= skidPc + PC_STEP;
                    IFID_valid <= 1'b1;
                    // Refill from the returning fetch so it is not lost behind the skid.
                    skidV      <= inflV;
                    if (inflV) begin
                        skidInstr <= imem_rdata;
                        skidPc    <= inflPc;
                    end
                end else if (inflV) begin
                    IFID_instr <= imem_rdata;
                    IFID_pc4   <= inflPc + PC_STEP;
                    IFID_valid <= 1'b1;
                end else begin
                    IFID_instr <= NOP_INSTR;
                    IFID_valid <= 1'b0;
                end
            end else if (inflV && !skidV) begin
                skidV     <= 1'b1;
                skidInstr <= imem_rdata;
                skidPc    <= inflPc;
            end
        end
    end

    fetch_unit_sat_counter #(.W(CNT_W)) uStallCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (~Redirect & ~IFIDWrite),
        .count (stall_cnt)
    );

    fetch_unit_sat_counter #(.W(CNT_W)) uFlushCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (Redirect),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit; imem returns 0x20 + address one cycle later.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        PCWrite = 1'b1;
    logic        IFIDWrite = 1'b1;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectPC = 32'h0;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] IFID_instr;
    logic [31:0] IFID_pc4;
    logic        IFID_valid;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int errors = 0;
    int checks = 0;

    fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .PCWrite    (PCWrite),
        .IFIDWrite  (IFIDWrite),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .IFID_instr (IFID_instr),
        .IFID_pc4   (IFID_pc4),
        .IFID_valid (IFID_valid),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= 32'h20 + imem_addr;
    end

    typedef struct {
        logic        p;
        logic        i;
        logic        r;
        logic [31:0] rpc;
        logic        en;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [15:0] stall;
        logic [15:0] flush;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic p, input logic i, input logic r, input logic [31:0] rpc,
                                input logic en, input logic [31:0] instr, input logic [31:0] pc4,
                                input logic valid, input logic [15:0] stall, input logic [15:0] flush);
        vec_t v;
        v.p = p; v.i = i; v.r = r; v.rpc = rpc; v.en = en;
        v.instr = instr; v.pc4 = pc4; v.valid = valid; v.stall = stall; v.flush = flush;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Starts and ends at a falling edge; inputs hold for one full cycle.
    task automatic step(input string name, input logic p, input logic i, input logic r,
                        input logic [31:0] rpc, input logic en, input logic [31:0] instr,
                        input logic [31:0] pc4, input logic valid);
        PCWrite = p; IFIDWrite = i; Redirect = r; RedirectPC = rpc;
        #1;
        chk({name, ".imem_en"}, 32'(imem_en), 32'(en));
        @(posedge clk);
        #1;
        chk({name, ".instr"}, IFID_instr, instr);
        chk({name, ".pc4"}, IFID_pc4, pc4);
        chk({name, ".valid"}, 32'(IFID_valid), 32'(valid));
        @(negedge clk);
    endtask

    initial begin
        // Reset release, stall of 3 cycles, redirect to 0x100, PCWrite-only drain.
        vecs[0]  = mk(1, 1, 0, 32'h0,   1, 32'h0,   32'h0,   0, 0, 0);
        vecs[1]  = mk(1, 1, 0, 32'h0,   1, 32'h20,  32'h4,   1, 0, 0);
        vecs[2]  = mk(1, 1, 0, 32'h0,   1, 32'h24,  32'h8,   1, 0, 0);
        vecs[3]  = mk(1, 1, 0, 32'h0,   1, 32'h28,  32'hC,   1, 0, 0);
        vecs[4]  = mk(0, 0, 0, 32'h0,   0, 32'h28,  32'hC,   1, 1, 0);
        vecs[5]  = mk(0, 0, 0, 32'h0,   0, 32'h28,  32'hC,   1, 2, 0);
        vecs[6]  = mk(0, 0, 0, 32'h0,   0, 32'h28,  32'hC,   1, 3, 0);
        vecs[7]  = mk(1, 1, 0, 32'h0,   1, 32'h2C,  32'h10,  1, 3, 0);
        vecs[8]  = mk(1, 1, 0, 32'h0,   1, 32'h30,  32'h14,  1, 3, 0);
        vecs[9]  = mk(1, 1, 0, 32'h0,   1, 32'h34,  32'h18,  1, 3, 0);
        vecs[10] = mk(1, 1, 1, 32'h100, 0, 32'h0,   32'h18,  0, 3, 1);
        vecs[11] = mk(1, 1, 0, 32'h0,   1, 32'h0,   32'h18,  0, 3, 1);
        vecs[12] = mk(1, 1, 0, 32'h0,   1, 32'h120, 32'h104, 1, 3, 1);
        vecs[13] = mk(1, 1, 0, 32'h0,   1, 32'h124, 32'h108, 1, 3, 1);
        vecs[14] = mk(0, 1, 0, 32'h0,   0, 32'h128, 32'h10C, 1, 3, 1);
        vecs[15] = mk(0, 1, 0, 32'h0,   0, 32'h0,   32'h10C, 0, 3, 1);
        vecs[16] = mk(1, 1, 0, 32'h0,   1, 32'h0,   32'h10C, 0, 3, 1);
        vecs[17] = mk(1, 1, 0, 32'h0,   1, 32'h12C, 32'h110, 1, 3, 1);

        #1 rst_n = 1'b0;
        #1;
        chk("rst.instr", IFID_instr, 32'h0);
        chk("rst.pc4", IFID_pc4, 32'h0);
        chk("rst.valid", 32'(IFID_valid), 32'h0);
        chk("rst.addr", imem_addr, 32'h0);
        chk("rst.stall", 32'(stall_cnt), 32'h0);
        chk("rst.flush", 32'(flush_cnt), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            step($sformatf("v%0d", k), vecs[k].p, vecs[k].i, vecs[k].r, vecs[k].rpc,
                 vecs[k].en, vecs[k].instr, vecs[k].pc4, vecs[k].valid);
            chk($sformatf("v%0d.stall", k), 32'(stall_cnt), 32'(vecs[k].stall));
            chk($sformatf("v%0d.flush", k), 32'(flush_cnt), 32'(vecs[k].flush));
        end

        // Redirect while stalled with the skid full: skid contents must never surface.
        step("skA", 0, 0, 0, 32'h0,   0, 32'h12C, 32'h110, 1);
        chk("skA.stall", 32'(stall_cnt), 32'd4);
        step("skB", 0, 0, 1, 32'h203, 0, 32'h0,   32'h110, 0);
        chk("skB.addr", imem_addr, 32'h200);
        chk("skB.flush", 32'(flush_cnt), 32'd2);
        chk("skB.stall", 32'(stall_cnt), 32'd4);
        step("skC", 1, 1, 0, 32'h0,   1, 32'h0,   32'h110, 0);
        step("skD", 1, 1, 0, 32'h0,   1, 32'h220, 32'h204, 1);
        step("skE", 1, 1, 0, 32'h0,   1, 32'h224, 32'h208, 1);

        // Async reset mid-stall with the skid loaded.
        PCWrite = 1'b0; IFIDWrite = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar.instr", IFID_instr, 32'h0);
        chk("ar.pc4", IFID_pc4, 32'h0);
        chk("ar.valid", 32'(IFID_valid), 32'h0);
        chk("ar.addr", imem_addr, 32'h0);
        chk("ar.stall", 32'(stall_cnt), 32'h0);
        chk("ar.flush", 32'(flush_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step("arR0", 1, 1, 0, 32'h0, 1, 32'h0,  32'h0, 0);
        step("arR1", 1, 1, 0, 32'h0, 1, 32'h20, 32'h4, 1);
        step("arR2", 1, 1, 0, 32'h0, 1, 32'h24, 32'h8, 1);

        // Long stall drives stall_cnt into saturation.
        PCWrite = 1'b0; IFIDWrite = 1'b0; Redirect = 1'b0;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        chk("sat.near", 32'(stall_cnt), 32'h0000_FFFE);
        chk("sat.hold", IFID_instr, 32'h24);
        @(negedge clk);
        chk("sat.max", 32'(stall_cnt), 32'h0000_FFFF);
        repeat (5) @(negedge clk);
        chk("sat.nowrap", 32'(stall_cnt), 32'h0000_FFFF);
        chk("sat.flush", 32'(flush_cnt), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
